// File: rtl/video_mem_port_if.sv
// Bus bundle for video_mem_port: video fetch port, CPU port and DRAM controller side.
// The responder (video_mem_port) uses the slave modport; requesters/bench use master.
interface video_mem_port_if;
  // Slot timing
  logic        dram_slot;
  logic        frame_sync;
  // Video fetch port
  logic        video_go;
  logic [1:0]  video_bw;
  logic [20:0] video_addr;
  logic        video_next;
  logic        video_strobe;
  logic [15:0] video_data;
  // CPU port
  logic        cpu_req;
  logic        cpu_rnw;
  logic [21:0] cpu_addr;
  logic [7:0]  cpu_wrdata;
  logic        cpu_next;
  logic        cpu_strobe;
  logic [7:0]  cpu_rddata;
  // DRAM controller side
  logic        dram_req;
  logic        dram_rnw;
  logic [20:0] dram_addr;
  logic [1:0]  dram_bsel;
  logic [15:0] dram_wrdata;
  logic [15:0] dram_rddata;

  modport slave (
    input  dram_slot, frame_sync,
    input  video_go, video_bw, video_addr,
    output video_next, video_strobe, video_data,
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wrdata,
    output cpu_next, cpu_strobe, cpu_rddata,
    output dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata,
    input  dram_rddata
  );

  modport master (
    output dram_slot, frame_sync,
    output video_go, video_bw, video_addr,
    input  video_next, video_strobe, video_data,
    output cpu_req, cpu_rnw, cpu_addr, cpu_wrdata,
    input  cpu_next, cpu_strobe, cpu_rddata,
    input  dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata,
    output dram_rddata
  );
endinterface

// File: rtl/video_mem_port.sv
// video_mem_port: DRAM slot responder for the video fetch port and the CPU port.
// Each dram_slot pulse grants one access to video or CPU based on video_bw and the
// slot counter; read data returns RD_LAT+2 clocks after the slot through a tag pipeline.
// Optional macro VPORT_CPU_FALLBACK_EN: hand unused video-eligible slots to the CPU.
module video_mem_port #(
  parameter int unsigned RD_LAT = 3
) (
  input logic           clk,
  input logic           rst,
  video_mem_port_if.slave bus
);

  localparam int unsigned NumStages = RD_LAT + 1;

  typedef struct packed {
    logic vid;
    logic cpurd;
    logic lowsel;
  } tag_t;

  logic [2:0]  sc_q;
  logic [2:0]  slot_idx;
  logic        video_elig;
  logic        grant_video;
  logic        grant_cpu;
  tag_t        tag_in;
  tag_t        tag_q [NumStages];

  logic        req_q;
  logic        rnw_q;
  logic [20:0] addr_q;
  logic [1:0]  bsel_q;
  logic [15:0] wrdata_q;
  logic        vnext_q;
  logic        cnext_q;
  logic        vstrobe_q;
  logic [15:0] vdata_q;
  logic        cstrobe_q;
  logic [7:0]  cdata_q;

  // Slot index and grant decision for a slot opening this cycle
  always_comb begin
    // A coincident frame_sync makes this slot index 0
    slot_idx   = bus.frame_sync ? 3'd0 : sc_q;
    video_elig = 1'b0;
    unique case (bus.video_bw)
      2'b00:   video_elig = (slot_idx == 3'd0);
      2'b01:   video_elig = (slot_idx[1:0] == 2'b00);
      2'b10:   video_elig = ~slot_idx[0];
      default: video_elig = 1'b1;
    endcase
    grant_video = video_elig & bus.video_go;
`ifdef VPORT_CPU_FALLBACK_EN
    grant_cpu   = bus.cpu_req & ~grant_video;
`else
    // Video-eligible slots stay reserved so CPU timing does not depend on video_go
    grant_cpu   = bus.cpu_req & ~video_elig;
`endif
    tag_in.vid    = bus.dram_slot & grant_video;
    tag_in.cpurd  = bus.dram_slot & grant_cpu & bus.cpu_rnw;
    tag_in.lowsel = ~bus.cpu_addr[0];
  end

  // Slot counter and registered DRAM request / next pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q     <= 3'd0;
      req_q    <= 1'b0;
      rnw_q    <= 1'b1;
      addr_q   <= '0;
      bsel_q   <= 2'b00;
      wrdata_q <= '0;
      vnext_q  <= 1'b0;
      cnext_q  <= 1'b0;
    end else begin
      req_q   <= 1'b0;
      vnext_q <= 1'b0;
      cnext_q <= 1'b0;
      if (bus.dram_slot) begin
        sc_q <= slot_idx + 3'd1;
        if (grant_video) begin
          req_q   <= 1'b1;
          vnext_q <= 1'b1;
          rnw_q   <= 1'b1;
          addr_q  <= bus.video_addr;
          bsel_q  <= 2'b11;
        end else if (grant_cpu) begin
          req_q    <= 1'b1;
          cnext_q  <= 1'b1;
          rnw_q    <= bus.cpu_rnw;
          addr_q   <= bus.cpu_addr[21:1];
          bsel_q   <= bus.cpu_addr[0] ? 2'b10 : 2'b01;
          wrdata_q <= {bus.cpu_wrdata, bus.cpu_wrdata};
        end
      end else if (bus.frame_sync) begin
        sc_q <= 3'd0;
      end
    end
  end

  // Tag pipeline: last stage lines up with the cycle dram_rddata is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NumStages); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < int'(NumStages); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Read data capture and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      vstrobe_q <= 1'b0;
      vdata_q   <= '0;
      cstrobe_q <= 1'b0;
      cdata_q   <= '0;
    end else begin
      vstrobe_q <= tag_q[RD_LAT].vid;
      cstrobe_q <= tag_q[RD_LAT].cpurd;
      if (tag_q[RD_LAT].vid) begin
        vdata_q <= bus.dram_rddata;
      end
      if (tag_q[RD_LAT].cpurd) begin
        cdata_q <= tag_q[RD_LAT].lowsel ? bus.dram_rddata[7:0] : bus.dram_rddata[15:8];
      end
    end
  end

  assign bus.dram_req     = req_q;
  assign bus.dram_rnw     = rnw_q;
  assign bus.dram_addr    = addr_q;
  assign bus.dram_bsel    = bsel_q;
  assign bus.dram_wrdata  = wrdata_q;
  assign bus.video_next   = vnext_q;
  assign bus.video_strobe = vstrobe_q;
  assign bus.video_data   = vdata_q;
  assign bus.cpu_next     = cnext_q;
  assign bus.cpu_strobe   = cstrobe_q;
  assign bus.cpu_rddata   = cdata_q;

endmodule

// File: tb/tb_video_mem_port.sv
// Bench for video_mem_port: table of isolated slot accesses plus hand-written
// sequences for frame_sync alignment, back-to-back slots and mid-operation reset.
module tb_video_mem_port;

  localparam int unsigned RD_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  video_mem_port_if vif ();

  video_mem_port #(.RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;

  // DRAM model: a read requested in cycle c returns f(addr) in cycle c+RD_LAT
  function automatic logic [15:0] mem_f(input logic [20:0] a);
    return a[15:0] ^ 16'hA55A;
  endfunction

  logic        hv [RD_LAT];
  logic [20:0] ha [RD_LAT];
  initial begin
    for (int i = 0; i < int'(RD_LAT); i++) begin
      hv[i] = 1'b0;
      ha[i] = '0;
    end
  end
  always @(posedge clk) begin
    #1;
    vif.dram_rddata = hv[RD_LAT-1] ? mem_f(ha[RD_LAT-1]) : 16'hDEAD;
    for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
      hv[i] = hv[i-1];
      ha[i] = ha[i-1];
    end
    hv[0] = vif.dram_req & vif.dram_rnw;
    ha[0] = vif.dram_addr;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        go;
    logic [1:0]  bw;
    logic        creq;
    logic        crnw;
    logic [21:0] caddr;
    logic [7:0]  cwr;
    logic [20:0] vaddr;
    logic        e_vnext;
    logic        e_cnext;
    logic        e_rnw;
    logic [20:0] e_addr;
    logic [1:0]  e_bsel;
    logic [15:0] e_wr;
    logic        e_vstb;
    logic        e_cstb;
    logic [15:0] e_vdata;
    logic [7:0]  e_cdata;
  } vec_t;

  vec_t vecs [12];

  // One isolated access: slot, grant checks, then strobe checks at slot+RD_LAT+2
  task automatic run_vec(input int i, input vec_t v);
    vif.video_go   = v.go;
    vif.video_bw   = v.bw;
    vif.video_addr = v.vaddr;
    vif.cpu_req    = v.creq;
    vif.cpu_rnw    = v.crnw;
    vif.cpu_addr   = v.caddr;
    vif.cpu_wrdata = v.cwr;
    vif.dram_slot  = 1'b1;
    step();
    vif.dram_slot = 1'b0;
    vif.cpu_req   = 1'b0;
    vif.video_go  = 1'b0;
    chk($sformatf("v%0d_req", i), 32'(vif.dram_req), 32'(v.e_vnext | v.e_cnext));
    chk($sformatf("v%0d_vnext", i), 32'(vif.video_next), 32'(v.e_vnext));
    chk($sformatf("v%0d_cnext", i), 32'(vif.cpu_next), 32'(v.e_cnext));
    if (v.e_vnext || v.e_cnext) begin
      chk($sformatf("v%0d_addr", i), 32'(vif.dram_addr), 32'(v.e_addr));
      chk($sformatf("v%0d_rnw", i), 32'(vif.dram_rnw), 32'(v.e_rnw));
      chk($sformatf("v%0d_bsel", i), 32'(vif.dram_bsel), 32'(v.e_bsel));
    end
    if (v.e_cnext && !v.crnw) begin
      chk($sformatf("v%0d_wrdata", i), 32'(vif.dram_wrdata), 32'(v.e_wr));
    end
    for (int j = 0; j < int'(RD_LAT); j++) begin
      step();
      chk($sformatf("v%0d_early_stb%0d", i, j), {30'd0, vif.video_strobe, vif.cpu_strobe}, 32'd0);
    end
    step();
    chk($sformatf("v%0d_vstb", i), 32'(vif.video_strobe), 32'(v.e_vstb));
    chk($sformatf("v%0d_cstb", i), 32'(vif.cpu_strobe), 32'(v.e_cstb));
    if (v.e_vstb) chk($sformatf("v%0d_vdata", i), 32'(vif.video_data), 32'(v.e_vdata));
    if (v.e_cstb) chk($sformatf("v%0d_cdata", i), 32'(vif.cpu_rddata), 32'(v.e_cdata));
    step();
    chk($sformatf("v%0d_stb_clear", i), {30'd0, vif.video_strobe, vif.cpu_strobe}, 32'd0);
  endtask

  // Plain video slot, returning the observed next pulses, then drain
  task automatic vslot(input logic fs, input logic go, input logic [1:0] bw,
                       output logic vn, output logic cn);
    vif.frame_sync = fs;
    vif.video_go   = go;
    vif.video_bw   = bw;
    vif.dram_slot  = 1'b1;
    step();
    vif.dram_slot  = 1'b0;
    vif.frame_sync = 1'b0;
    vif.video_go   = 1'b0;
    vn = vif.video_next;
    cn = vif.cpu_next;
    if (cn) vif.cpu_req = 1'b0;
    for (int j = 0; j < int'(RD_LAT) + 2; j++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic vn, cn;
    logic [20:0] vbase;
    int nstb;

    vif.dram_slot   = 1'b0;
    vif.frame_sync  = 1'b0;
    vif.video_go    = 1'b0;
    vif.video_bw    = 2'b00;
    vif.video_addr  = '0;
    vif.cpu_req     = 1'b0;
    vif.cpu_rnw     = 1'b1;
    vif.cpu_addr    = '0;
    vif.cpu_wrdata  = '0;
    vif.dram_rddata = 16'hDEAD;

    //         go  bw    creq crnw caddr       cwr    vaddr       vnx cnx rnw addr        bsel   wr        vst cst vdata     cdata
    vecs[0]  = '{1, 2'b01, 0, 1, 22'h000000, 8'h00, 21'h000010, 1, 0, 1, 21'h000010, 2'b11, 16'h0000, 1, 0, 16'hA54A, 8'h00};
    vecs[1]  = '{1, 2'b01, 0, 1, 22'h000000, 8'h00, 21'h000011, 0, 0, 1, 21'h000000, 2'b00, 16'h0000, 0, 0, 16'h0000, 8'h00};
    vecs[2]  = '{1, 2'b01, 0, 1, 22'h000000, 8'h00, 21'h000011, 0, 0, 1, 21'h000000, 2'b00, 16'h0000, 0, 0, 16'h0000, 8'h00};
    vecs[3]  = '{1, 2'b01, 0, 1, 22'h000000, 8'h00, 21'h000011, 0, 0, 1, 21'h000000, 2'b00, 16'h0000, 0, 0, 16'h0000, 8'h00};
    vecs[4]  = '{1, 2'b01, 0, 1, 22'h000000, 8'h00, 21'h000020, 1, 0, 1, 21'h000020, 2'b11, 16'h0000, 1, 0, 16'hA57A, 8'h00};
    vecs[5]  = '{1, 2'b01, 1, 1, 22'h000001, 8'h00, 21'h000021, 0, 1, 1, 21'h000000, 2'b10, 16'h0000, 0, 1, 16'h0000, 8'hA5};
    vecs[6]  = '{0, 2'b01, 1, 0, 22'h000104, 8'h3C, 21'h000021, 0, 1, 0, 21'h000082, 2'b01, 16'h3C3C, 0, 0, 16'h0000, 8'h00};
    vecs[7]  = '{1, 2'b11, 1, 1, 22'h000002, 8'h00, 21'h1FFFFF, 1, 0, 1, 21'h1FFFFF, 2'b11, 16'h0000, 1, 0, 16'h5AA5, 8'h00};
`ifdef VPORT_CPU_FALLBACK_EN
    vecs[8]  = '{0, 2'b00, 1, 1, 22'h000006, 8'h00, 21'h000030, 0, 1, 1, 21'h000003, 2'b01, 16'h0000, 0, 1, 16'h0000, 8'h59};
`else
    vecs[8]  = '{0, 2'b00, 1, 1, 22'h000006, 8'h00, 21'h000030, 0, 0, 1, 21'h000000, 2'b00, 16'h0000, 0, 0, 16'h0000, 8'h00};
`endif
    vecs[9]  = '{1, 2'b10, 1, 1, 22'h3FFFFF, 8'h00, 21'h000040, 0, 1, 1, 21'h1FFFFF, 2'b10, 16'h0000, 0, 1, 16'h0000, 8'h5A};
    vecs[10] = '{1, 2'b10, 0, 1, 22'h000000, 8'h00, 21'h012345, 1, 0, 1, 21'h012345, 2'b11, 16'h0000, 1, 0, 16'h861F, 8'h00};
    vecs[11] = '{1, 2'b00, 0, 1, 22'h000000, 8'h00, 21'h000050, 0, 0, 1, 21'h000000, 2'b00, 16'h0000, 0, 0, 16'h0000, 8'h00};

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_req", 32'(vif.dram_req), 32'd0);
    chk("rst_next", {30'd0, vif.video_next, vif.cpu_next}, 32'd0);
    chk("rst_strobe", {30'd0, vif.video_strobe, vif.cpu_strobe}, 32'd0);
    chk("rst_rnw", 32'(vif.dram_rnw), 32'd1);
    chk("rst_bsel", 32'(vif.dram_bsel), 32'd0);
    chk("rst_addr", 32'(vif.dram_addr), 32'd0);
    chk("rst_wrdata", 32'(vif.dram_wrdata), 32'd0);
    chk("rst_vdata", 32'(vif.video_data), 32'd0);
    chk("rst_cdata", 32'(vif.cpu_rddata), 32'd0);

    // Table: slot indices 0..7 then 0..3
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // frame_sync with a slot at sc=5: treated as index 0, next slot is index 1
    vslot(1'b0, 1'b0, 2'b00, vn, cn);
    vslot(1'b1, 1'b1, 2'b00, vn, cn);
    chk("fs_slot_grant", 32'(vn), 32'd1);
    vslot(1'b0, 1'b1, 2'b10, vn, cn);
    chk("fs_idx1_idle", 32'(vn), 32'd0);
    vslot(1'b0, 1'b1, 2'b10, vn, cn);
    chk("fs_idx2_grant", 32'(vn), 32'd1);
    // frame_sync alone clears the counter
    vif.frame_sync = 1'b1;
    step();
    vif.frame_sync = 1'b0;
    step();
    vslot(1'b0, 1'b1, 2'b00, vn, cn);
    chk("fs_alone_idx0", 32'(vn), 32'd1);

    // Back-to-back: bw=11, video_go and cpu_req held, 8 slots 2 clk apart
    vbase          = 21'h000100;
    vif.video_addr = vbase;
    vif.video_bw   = 2'b11;
    vif.video_go   = 1'b1;
    vif.cpu_req    = 1'b1;
    vif.cpu_rnw    = 1'b1;
    nstb = 0;
    for (int t = 0; t < 24; t++) begin
      vif.dram_slot = (t < 16) && (t % 2 == 0);
      step();
      vif.dram_slot = 1'b0;
      chk($sformatf("b2b_t%0d_vnext", t), 32'(vif.video_next), 32'((t < 16) && (t % 2 == 0)));
      chk($sformatf("b2b_t%0d_cnext", t), 32'(vif.cpu_next), 32'd0);
      chk($sformatf("b2b_t%0d_vstb", t), 32'(vif.video_strobe),
          32'((t >= 4) && (t < 20) && (t % 2 == 0)));
      if (vif.video_strobe) begin
        chk($sformatf("b2b_stb%0d_data", nstb), 32'(vif.video_data),
            32'(mem_f(vbase + 21'(nstb))));
        nstb++;
      end
      if (vif.video_next) vif.video_addr = vif.video_addr + 21'd1;
    end
    chk("b2b_strobe_count", 32'(nstb), 32'd8);
    vif.video_go = 1'b0;
    vif.cpu_req  = 1'b0;

    // Reset one clk after a video grant drops the outstanding tag
    vif.video_bw  = 2'b11;
    vif.video_go  = 1'b1;
    vif.dram_slot = 1'b1;
    step();
    vif.dram_slot = 1'b0;
    vif.video_go  = 1'b0;
    chk("mid_rst_grant", 32'(vif.video_next), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req", 32'(vif.dram_req), 32'd0);
    chk("mid_rst_next", {30'd0, vif.video_next, vif.cpu_next}, 32'd0);
    chk("mid_rst_rnw", 32'(vif.dram_rnw), 32'd1);
    chk("mid_rst_bsel", 32'(vif.dram_bsel), 32'd0);
    chk("mid_rst_addr", 32'(vif.dram_addr), 32'd0);
    chk("mid_rst_wrdata", 32'(vif.dram_wrdata), 32'd0);
    chk("mid_rst_vdata", 32'(vif.video_data), 32'd0);
    for (int j = 0; j < int'(RD_LAT) + 3; j++) begin
      chk($sformatf("mid_rst_nostb%0d", j), {30'd0, vif.video_strobe, vif.cpu_strobe}, 32'd0);
      step();
    end

    // cpu_req held across reset is served again; counter restarted at 0
    vif.cpu_req  = 1'b1;
    vif.cpu_rnw  = 1'b0;
    vif.cpu_addr = 22'h000010;
`ifdef VPORT_CPU_FALLBACK_EN
    vslot(1'b0, 1'b0, 2'b00, vn, cn);
    chk("post_rst_cpu_idx0", 32'(cn), 32'd1);
`else
    vslot(1'b0, 1'b0, 2'b00, vn, cn);
    chk("post_rst_cpu_idx0", 32'(cn), 32'd0);
    vslot(1'b0, 1'b0, 2'b00, vn, cn);
    chk("post_rst_cpu_idx1", 32'(cn), 32'd1);
`endif
    vif.cpu_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
